// File: rtl/tt_sweep_ctrl.sv
// rtl/tt_sweep_ctrl.sv - exhaustive truth-table sweep sequencer for one gate-under-test
`timescale 1ns/1ps
module tt_sweep_ctrl #(
    parameter int                     N_IN          = 4,
    parameter logic [(1<<N_IN)-1:0]   EXPECTED      = 16'h8F63,
    parameter int                     SETTLE_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    output logic [N_IN-1:0]       gate_in,
    input  logic                  gate_out,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [(1<<N_IN)-1:0]  tt_observed,
    output logic [N_IN:0]         mismatch_count,
    output logic [N_IN-1:0]       first_fail_idx
);

    localparam int NV = 1 << N_IN;
    localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int MW = N_IN + 1;
    localparam logic [N_IN-1:0] LAST_IDX = N_IN'(NV - 1);
    localparam logic [CW-1:0]   CNT_LOAD = CW'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_SAMPLE, S_DONE} state_t;

    state_t          state_q, state_d;
    logic [N_IN-1:0] idx_q, idx_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [N_IN-1:0] gate_q, gate_d;
    logic [NV-1:0]   tt_q, tt_d;
    logic [MW-1:0]   mm_q, mm_d;
    logic [N_IN-1:0] ffi_q, ffi_d;
    logic            pass_q, pass_d;
    logic            done_q, done_d;
    logic            busy_q, busy_d;
    logic            miss;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start) state_d = S_SETTLE;
            S_SETTLE: begin
                if (abort)               state_d = S_IDLE;
                else if (cnt_q == '0)    state_d = S_SAMPLE;
            end
            S_SAMPLE: begin
                if (abort)                  state_d = S_IDLE;
                else if (idx_q == LAST_IDX) state_d = S_DONE;
                else                        state_d = S_SETTLE;
            end
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Datapath next-state; abort wins over the SAMPLE capture so a cancelled
    // vector never reaches the truth table or the mismatch count.
    always_comb begin
        idx_d  = idx_q;
        cnt_d  = cnt_q;
        gate_d = gate_q;
        tt_d   = tt_q;
        mm_d   = mm_q;
        ffi_d  = ffi_q;
        pass_d = pass_q;
        done_d = 1'b0;
        miss   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    idx_d  = '0;
                    gate_d = '0;
                    tt_d   = '0;
                    mm_d   = '0;
                    ffi_d  = '0;
                    pass_d = 1'b0;
                    cnt_d  = CNT_LOAD;
                end
            end
            S_SETTLE: begin
                if (abort) begin
                    gate_d = '0;
                    pass_d = 1'b0;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_SAMPLE: begin
                if (abort) begin
                    gate_d = '0;
                    pass_d = 1'b0;
                end else begin
                    tt_d[idx_q] = gate_out;
                    miss = (gate_out != EXPECTED[idx_q]);
                    if (miss) begin
                        mm_d = mm_q + MW'(1);
                        if (mm_q == '0) ffi_d = idx_q;
                    end
                    if (idx_q == LAST_IDX) begin
                        done_d = 1'b1;
                        pass_d = (mm_d == '0);
                    end else begin
                        idx_d  = idx_q + N_IN'(1);
                        gate_d = idx_q + N_IN'(1);
                        cnt_d  = CNT_LOAD;
                    end
                end
            end
            default: ;
        endcase
        busy_d = (state_d == S_SETTLE) || (state_d == S_SAMPLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q  <= '0;
            cnt_q  <= '0;
            gate_q <= '0;
            tt_q   <= '0;
            mm_q   <= '0;
            ffi_q  <= '0;
            pass_q <= 1'b0;
            done_q <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            idx_q  <= idx_d;
            cnt_q  <= cnt_d;
            gate_q <= gate_d;
            tt_q   <= tt_d;
            mm_q   <= mm_d;
            ffi_q  <= ffi_d;
            pass_q <= pass_d;
            done_q <= done_d;
            busy_q <= busy_d;
        end
    end

    assign gate_in        = gate_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign tt_observed    = tt_q;
    assign mismatch_count = mm_q;
    assign first_fail_idx = ffi_q;

endmodule
